pwm_update_arbiter: RTL and testbench

PWM_UPDATE_ARBITER -- requirements
Module: pwm_update_arbiter

---
 rtl/pwm_update_arbiter.sv | 118 +++++++++++
 tb/tb_pwm_update_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_update_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one PWM core; an accepted
// top/compare update is held in a shadow stage and applied at the next period boundary.
module pwm_update_arbiter #(
  parameter int         N_REQ   = 4,
  parameter logic [7:0] RST_TOP = 8'hff
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [8*N_REQ-1:0] i_req_top,
  input  logic [9*N_REQ-1:0] i_req_compare,
  output logic [N_REQ-1:0]   o_req_ready,
  input  logic               i_period_end,
  output logic [7:0]         o_top,
  output logic [8:0]         o_compare,
  output logic               o_load,
  output logic [2:0]         o_src,
  output logic               o_busy
);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [2:0]           ptr_q;
  logic [2:0]           gnt_idx;
  logic                 gnt_vld;
  logic [2*N_REQ-1:0]   vld_rot;
  logic [3:0]           idx_sum;
  logic [7:0]           sel_top;
  logic [8:0]           sel_cmp;
  logic [7:0]           top_p0;
  logic [8:0]           cmp_p0;
  logic [2:0]           src_p0;

  // Compare limit is top+1 at 9 bits so top=8'hff still allows a full-period duty.
  function automatic logic [8:0] clamp_cmp(input logic [7:0] top, input logic [8:0] cmp);
    logic [8:0] lim;
    lim = {1'b0, top} + 9'd1;
    return (cmp > lim) ? lim : cmp;
  endfunction

  function automatic logic [2:0] next_ptr(input logic [2:0] idx);
    return (idx == 3'(N_REQ - 1)) ? 3'd0 : idx + 3'd1;
  endfunction

  // Arbitration: rotate valid by the pointer and take the lowest set bit.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx_sum = '0;
    vld_rot = {i_req_valid, i_req_valid} >> ptr_q;
    if (state_q == IDLE && !i_rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!gnt_vld && vld_rot[i]) begin
          gnt_vld = 1'b1;
          idx_sum = 4'(ptr_q) + 4'(i);
          if (idx_sum >= 4'(N_REQ)) idx_sum = idx_sum - 4'(N_REQ);
          gnt_idx = idx_sum[2:0];
        end
      end
    end
  end

  always_comb begin
    sel_top = '0;
    sel_cmp = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_idx == 3'(k)) begin
        sel_top = i_req_top[8*k +: 8];
        sel_cmp = i_req_compare[9*k +: 9];
      end
    end
  end

  assign o_req_ready = gnt_vld ? (N_REQ'(1) << gnt_idx) : '0;
  assign o_busy      = (state_q == PENDING);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld) state_d = PENDING;
      PENDING: if (i_period_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: shadow capture on transfer (data only, no reset needed)
  always_ff @(posedge i_clk) begin
    if (gnt_vld) begin
      top_p0 <= sel_top;
      cmp_p0 <= clamp_cmp(sel_top, sel_cmp);
      src_p0 <= gnt_idx;
    end
  end

  // Stage p1: commit shadow to the PWM core at the period boundary
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      o_top     <= RST_TOP;
      o_compare <= '0;
      o_src     <= '0;
      o_load    <= 1'b0;
    end else begin
      state_q <= state_d;
      o_load  <= 1'b0;
      if (gnt_vld) ptr_q <= next_ptr(gnt_idx);
      if (state_q == PENDING && i_period_end) begin
        o_top     <= top_p0;
        o_compare <= cmp_p0;
        o_src     <= src_p0;
        o_load    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_update_arbiter.sv
// Directed bench for pwm_update_arbiter with a transaction-level reference model
// checked every cycle plus literal expectations for each scenario.
module tb_pwm_update_arbiter;
  localparam int N = 4;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [N-1:0]  valid;
  logic [8*N-1:0] top_bus;
  logic [9*N-1:0] cmp_bus;
  logic [N-1:0]  o_req_ready;
  logic          pe;
  logic [7:0]    o_top;
  logic [8:0]    o_compare;
  logic          o_load;
  logic [2:0]    o_src;
  logic          o_busy;

  pwm_update_arbiter #(.N_REQ(N), .RST_TOP(8'hff)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(valid), .i_req_top(top_bus),
    .i_req_compare(cmp_bus), .o_req_ready(o_req_ready), .i_period_end(pe),
    .o_top(o_top), .o_compare(o_compare), .o_load(o_load), .o_src(o_src), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit drop_on_grant;

  // reference model state
  bit m_pend, m_load;
  int m_ptr, m_sh_top, m_sh_cmp, m_sh_src, m_top, m_cmp, m_src;
  int grant_q[$], grant_cyc_q[$], load_cyc_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int clampv(input int top, input int cmp);
    return (cmp < top + 1) ? cmp : top + 1;
  endfunction

  function automatic int m_pick();
    if (i_rst || m_pend) return -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (valid[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_load = 0; m_ptr = 0;
    m_top = 'hff; m_cmp = 0; m_src = 0;
  endtask

  // One clock cycle: compare DUT against model, advance model, cross the edge.
  task automatic tick();
    int g;
    #1;
    if (i_rst) model_reset();
    g = m_pick();
    chk("ready",   int'(o_req_ready), (g < 0) ? 0 : (1 << g));
    chk("busy",    int'(o_busy),      int'(m_pend));
    chk("load",    int'(o_load),      int'(m_load));
    chk("top",     int'(o_top),       m_top);
    chk("compare", int'(o_compare),   m_cmp);
    chk("src",     int'(o_src),       m_src);
    if (o_load) load_cyc_q.push_back(cyc);
    if (g >= 0) begin grant_q.push_back(g); grant_cyc_q.push_back(cyc); end
    if (i_rst) model_reset();
    else begin
      m_load = 0;
      if (m_pend && pe) begin
        m_top = m_sh_top; m_cmp = m_sh_cmp; m_src = m_sh_src;
        m_load = 1; m_pend = 0;
      end else if (g >= 0) begin
        m_sh_top = int'(top_bus[8*g +: 8]);
        m_sh_cmp = clampv(m_sh_top, int'(cmp_bus[9*g +: 9]));
        m_sh_src = g;
        m_ptr    = (g + 1) % N;
        m_pend   = 1;
      end
    end
    @(posedge i_clk);
    #1;
    cyc++;
    if (g >= 0 && drop_on_grant) valid[g] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int exp_rr[5];
    exp_rr = '{0, 1, 2, 3, 0};
    i_rst = 1'b1; valid = '0; top_bus = '0; cmp_bus = '0; pe = 1'b0; drop_on_grant = 1;
    model_reset();
    @(posedge i_clk); #1;

    // reset holds outputs and masks ready even with a valid request
    valid[1] = 1'b1;
    tick(); tick();
    chk("rst_top", int'(o_top), 'hff);
    chk("rst_ready", int'(o_req_ready), 0);

    // single requester
    i_rst = 1'b0;
    top_bus[15:8] = 8'h7f; cmp_bus[17:9] = 9'h040;
    #1 chk("s1_ready", int'(o_req_ready), 'b0010);
    tick();
    chk("s1_busy", int'(o_busy), 1);
    chk("s1_ready_low", int'(o_req_ready), 0);
    repeat (4) tick();
    pe = 1'b1; tick(); pe = 1'b0;
    chk("s1_load", int'(o_load), 1);
    chk("s1_top", int'(o_top), 'h7f);
    chk("s1_cmp", int'(o_compare), 'h040);
    chk("s1_src", int'(o_src), 1);
    tick();
    chk("s1_load_pulse", int'(o_load), 0);

    // round robin with all requesters continuously valid
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    drop_on_grant = 0;
    for (int k = 0; k < N; k++) begin
      top_bus[8*k +: 8] = 8'(8'h20 + k);
      cmp_bus[9*k +: 9] = 9'(9'h010 + k);
    end
    valid = '1;
    grant_q.delete(); grant_cyc_q.delete(); load_cyc_q.delete();
    for (int c = 0; c < 50; c++) begin
      pe = (c % 10 == 9);
      tick();
    end
    pe = 1'b0; valid = '0; tick();
    chk("rr_count", grant_q.size(), 5);
    for (int k = 0; k < 5; k++)
      chk("rr_grant", (k < grant_q.size()) ? grant_q[k] : -1, exp_rr[k]);
    for (int k = 1; k < 5; k++)
      chk("rr_after_load",
          (k < grant_cyc_q.size()) ? grant_cyc_q[k] : -1,
          (k - 1 < load_cyc_q.size()) ? load_cyc_q[k-1] : -2);
    chk("rr_top", int'(o_top), 'h20);
    drop_on_grant = 1;

    // compare clamping
    valid = 4'b0100; top_bus[23:16] = 8'h10; cmp_bus[26:18] = 9'h1ff;
    tick(); pe = 1'b1; tick(); pe = 1'b0;
    chk("clamp_lo", int'(o_compare), 'h011);
    chk("clamp_src", int'(o_src), 2);
    valid = 4'b1000; top_bus[31:24] = 8'hff; cmp_bus[35:27] = 9'h100;
    tick(); pe = 1'b1; tick(); pe = 1'b0;
    chk("clamp_full", int'(o_compare), 'h100);
    chk("clamp_full_top", int'(o_top), 'hff);
    valid = 4'b0001; top_bus[7:0] = 8'h20; cmp_bus[8:0] = 9'h005;
    tick(); pe = 1'b1; tick(); pe = 1'b0;
    chk("clamp_pass", int'(o_compare), 'h005);

    // transfer colliding with period_end
    valid[1] = 1'b1;
    pe = 1'b1; tick(); pe = 1'b0;
    chk("col_noload", int'(o_load), 0);
    chk("col_busy", int'(o_busy), 1);
    tick(); tick();
    pe = 1'b1; tick(); pe = 1'b0;
    chk("col_load", int'(o_load), 1);
    chk("col_src", int'(o_src), 1);
    tick();

    // reset while pending discards the update
    valid[2] = 1'b1; top_bus[23:16] = 8'h33; cmp_bus[26:18] = 9'h022;
    tick(); tick();
    chk("rp_busy", int'(o_busy), 1);
    i_rst = 1'b1;
    #1;
    chk("rp_async_busy", int'(o_busy), 0);
    chk("rp_async_top", int'(o_top), 'hff);
    tick();
    i_rst = 1'b0;
    tick();
    pe = 1'b1; tick(); pe = 1'b0;
    chk("rp_noload", int'(o_load), 0);
    chk("rp_top", int'(o_top), 'hff);
    chk("rp_cmp", int'(o_compare), 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
